// File: rtl/req_encoder32_5_if.sv
// Request/offer bundle for the pending-request encoder.
// The encoder takes the slave side; whoever drives requests and consumes indices takes the master side.
interface req_encoder32_5_if #(
  parameter int N = 32,
  parameter int W = 5
);
  logic [N-1:0] req;
  logic [N-1:0] clr;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic [W:0]   count;

  modport master (
    output req, clr, out_ready,
    input  out_valid, out_idx, pending, count
  );

  modport slave (
    input  req, clr, out_ready,
    output out_valid, out_idx, pending, count
  );
endinterface

// File: rtl/req_encoder32_5.sv
// Pending-request encoder: sticky 32-bit request set serialised as 5-bit indices over valid/ready,
// with fixed lowest-first or round-robin priority.
module req_encoder32_5 #(
  parameter int N  = 32,
  parameter int W  = 5,
  parameter int RR = 1
) (
  input  logic             clk,
  input  logic             reset,
  req_encoder32_5_if.slave bus
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] idx, idx_nxt;
  logic [N-1:0] pend, pend_nxt;
  logic [W:0]   cnt;
  logic         pop;
  logic [N-1:0] popmask;
  logic [N-1:0] rem;
  logic [N-1:0] avail;

  // First set bit at or above p, wrapping; lower offsets overwrite later ones so the nearest wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] s, input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
    for (int k = N - 1; k >= 0; k--) begin
      if (s[p + W'(k)]) r = p + W'(k);
    end
    return r;
  endfunction

  function automatic logic [W:0] popcnt(input logic [N-1:0] s);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + (W+1)'(s[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
      pend  <= pend_nxt;
      cnt   <= popcnt(pend_nxt);
    end
  end

  // A re-request of the popped bit survives because req is ORed in after the removals.
  always_comb begin
    pop       = (state == OFFER) && bus.out_ready;
    popmask   = pop ? (N'(1) << idx) : '0;
    rem       = pend & ~popmask & ~bus.clr;
    avail     = pend & ~bus.clr;
    pend_nxt  = rem | bus.req;
    ptr_nxt   = ptr;
    state_nxt = state;
    idx_nxt   = idx;
    if ((RR != 0) && pop) ptr_nxt = idx + W'(1);
    case (state)
      IDLE: begin
        if (avail != '0) begin
          state_nxt = OFFER;
          idx_nxt   = pick(avail, ptr);
        end
      end
      OFFER: begin
        if (pop) begin
          if (rem != '0) idx_nxt = pick(rem, ptr_nxt);
          else           state_nxt = IDLE;
        end else if (bus.clr[idx]) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bus.out_valid = (state == OFFER);
    bus.out_idx   = idx;
    bus.pending   = pend;
    bus.count     = cnt;
  end

endmodule

// File: tb/tb_req_encoder32_5.sv
// Self-checking bench: a fixed-priority and a round-robin encoder driven side by side,
// checked against directed constants and a bit-set reference model.
module tb_req_encoder32_5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  req_encoder32_5_if ifx ();
  req_encoder32_5_if irr ();

  req_encoder32_5 #(.N(32), .W(5), .RR(0)) dut_fx (.clk(clk), .reset(reset), .bus(ifx.slave));
  req_encoder32_5 #(.N(32), .W(5), .RR(1)) dut_rr (.clk(clk), .reset(reset), .bus(irr.slave));

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: 0 = fixed priority, 1 = round robin.
  logic [31:0] mpend [2];
  int          mptr  [2];
  bit          mval  [2];
  int          midx  [2];

  function automatic logic ov(input int m);
    return (m == 1) ? irr.out_valid : ifx.out_valid;
  endfunction
  function automatic logic [4:0] oi(input int m);
    return (m == 1) ? irr.out_idx : ifx.out_idx;
  endfunction
  function automatic logic [31:0] op(input int m);
    return (m == 1) ? irr.pending : ifx.pending;
  endfunction
  function automatic logic [5:0] oc(input int m);
    return (m == 1) ? irr.count : ifx.count;
  endfunction

  function automatic int mpick(input logic [31:0] s, input int p);
    for (int k = 0; k < 32; k++) begin
      if (s[(p + k) % 32]) return (p + k) % 32;
    end
    return 0;
  endfunction

  task automatic model_update(input logic [31:0] r, input logic [31:0] c, input logic rdy, input logic rst);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mpend[m] = '0;
        mptr[m]  = 0;
        mval[m]  = 1'b0;
        midx[m]  = 0;
      end else begin
        logic [31:0] left;
        bit          popped;
        popped = mval[m] && rdy;
        left   = mpend[m] & ~c;
        if (popped) left[midx[m]] = 1'b0;
        if (!mval[m]) begin
          if ((mpend[m] & ~c) != 0) begin
            mval[m] = 1'b1;
            midx[m] = mpick(mpend[m] & ~c, mptr[m]);
          end
        end else if (popped) begin
          if (m == 1) mptr[m] = (midx[m] + 1) % 32;
          if (left != 0) midx[m] = mpick(left, mptr[m]);
          else           mval[m] = 1'b0;
        end else if (c[midx[m]]) begin
          mval[m] = 1'b0;
        end
        mpend[m] = left | r;
      end
    end
  endtask

  task automatic step(input logic [31:0] r, input logic [31:0] c, input logic rdy, input logic rst);
    ifx.req = r;  irr.req = r;
    ifx.clr = c;  irr.clr = c;
    ifx.out_ready = rdy;
    irr.out_ready = rdy;
    reset = rst;
    @(posedge clk);
    model_update(r, c, rdy, rst);
    #1;
  endtask

  task automatic test_reset;
    step('0, '0, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid m=%0d got=%b exp=0", m, ov(m)); end
      checks++;
      if (op(m) !== 32'h0) begin failures++; $display("[TB] FAIL reset_pending m=%0d got=%h exp=0", m, op(m)); end
      checks++;
      if (oc(m) !== 6'd0) begin failures++; $display("[TB] FAIL reset_count m=%0d got=%0d exp=0", m, oc(m)); end
    end
  endtask

  task automatic test_single;
    step(32'h20, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0 || op(m) !== 32'h20) begin
        failures++; $display("[TB] FAIL single_t1 m=%0d valid=%b pending=%h exp valid=0 pending=20", m, ov(m), op(m));
      end
    end
    step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oi(m) !== 5'd5 || oc(m) !== 6'd1) begin
        failures++; $display("[TB] FAIL single_t2 m=%0d valid=%b idx=%0d count=%0d exp 1/5/1", m, ov(m), oi(m), oc(m));
      end
    end
    step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0 || oc(m) !== 6'd0) begin
        failures++; $display("[TB] FAIL single_pop m=%0d valid=%b count=%0d exp 0/0", m, ov(m), oc(m));
      end
    end
  endtask

  task automatic test_fixed_order;
    int exp_seq [3] = '{0, 4, 31};
    step('0, '0, 1'b0, 1'b1);
    step(32'h8000_0011, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (ov(m) !== 1'b1 || oi(m) !== 5'(exp_seq[i])) begin
          failures++; $display("[TB] FAIL order_%0d m=%0d valid=%b idx=%0d exp idx=%0d", i, m, ov(m), oi(m), exp_seq[i]);
        end
      end
      step('0, '0, 1'b1, 1'b0);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0) begin failures++; $display("[TB] FAIL order_drain m=%0d valid=%b exp=0", m, ov(m)); end
    end
  endtask

  task automatic test_rr_wrap;
    int exp_first [2] = '{3, 9};
    int exp_second[2] = '{9, 3};
    step('0, '0, 1'b0, 1'b1);
    step(32'h10, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(32'h208, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oi(m) !== 5'(exp_first[m])) begin
        failures++; $display("[TB] FAIL rr_first m=%0d valid=%b idx=%0d exp idx=%0d", m, ov(m), oi(m), exp_first[m]);
      end
    end
    step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oi(m) !== 5'(exp_second[m])) begin
        failures++; $display("[TB] FAIL rr_second m=%0d valid=%b idx=%0d exp idx=%0d", m, ov(m), oi(m), exp_second[m]);
      end
    end
    step('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    int exp_after[2][2] = '{'{0, 2}, '{2, 0}};
    step('0, '0, 1'b0, 1'b1);
    step(32'h6, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step((i == 1) ? 32'h1 : 32'h0, '0, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (ov(m) !== 1'b1 || oi(m) !== 5'd1) begin
          failures++; $display("[TB] FAIL stall_%0d m=%0d valid=%b idx=%0d exp 1/1", i, m, ov(m), oi(m));
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (op(m) !== 32'h7 || oc(m) !== 6'd3) begin
        failures++; $display("[TB] FAIL stall_pending m=%0d pending=%h count=%0d exp 7/3", m, op(m), oc(m));
      end
    end
    for (int i = 0; i < 2; i++) begin
      step('0, '0, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (ov(m) !== 1'b1 || oi(m) !== 5'(exp_after[m][i])) begin
          failures++; $display("[TB] FAIL release_%0d m=%0d valid=%b idx=%0d exp idx=%0d", i, m, ov(m), oi(m), exp_after[m][i]);
        end
      end
    end
    step('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_repop_and_clr;
    step('0, '0, 1'b0, 1'b1);
    step(32'h80, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(32'h80, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (op(m) !== 32'h80 || ov(m) !== 1'b0) begin
        failures++; $display("[TB] FAIL repop_kept m=%0d pending=%h valid=%b exp 80/0", m, op(m), ov(m));
      end
    end
    step('0, '0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oi(m) !== 5'd7) begin
        failures++; $display("[TB] FAIL repop_offer m=%0d valid=%b idx=%0d exp 1/7", m, ov(m), oi(m));
      end
    end
    step('0, 32'h80, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0 || op(m) !== 32'h0 || oc(m) !== 6'd0) begin
        failures++; $display("[TB] FAIL clr_withdraw m=%0d valid=%b pending=%h count=%0d exp 0/0/0", m, ov(m), op(m), oc(m));
      end
    end
  endtask

  task automatic test_reset_in_offer;
    step('0, '0, 1'b0, 1'b1);
    step(32'h111, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oc(m) !== 6'd3) begin
        failures++; $display("[TB] FAIL pre_reset m=%0d valid=%b count=%0d exp 1/3", m, ov(m), oc(m));
      end
    end
    step(32'h4, 32'h0, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b0 || op(m) !== 32'h0 || oc(m) !== 6'd0) begin
        failures++; $display("[TB] FAIL mid_reset m=%0d valid=%b pending=%h count=%0d exp 0/0/0", m, ov(m), op(m), oc(m));
      end
    end
    step(32'h20, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov(m) !== 1'b1 || oi(m) !== 5'd5) begin
        failures++; $display("[TB] FAIL post_reset m=%0d valid=%b idx=%0d exp 1/5", m, ov(m), oi(m));
      end
    end
    step('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [31:0] c;
    logic        rdy;
    logic        rst;
    step('0, '0, 1'b0, 1'b1);
    for (int t = 0; t < 600; t++) begin
      r   = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      c   = ($urandom_range(0, 5) == 0) ? ($urandom & $urandom) : 32'h0;
      if ($urandom_range(0, 9) == 0 && mval[0]) c[midx[0]] = 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      step(r, c, rdy, rst);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (ov(m) !== mval[m]) begin
          failures++; $display("[TB] FAIL rnd_valid t=%0d m=%0d got=%b exp=%b", t, m, ov(m), mval[m]);
        end
        if (mval[m]) begin
          checks++;
          if (oi(m) !== 5'(midx[m])) begin
            failures++; $display("[TB] FAIL rnd_idx t=%0d m=%0d got=%0d exp=%0d", t, m, oi(m), midx[m]);
          end
        end
        checks++;
        if (op(m) !== mpend[m]) begin
          failures++; $display("[TB] FAIL rnd_pending t=%0d m=%0d got=%h exp=%h", t, m, op(m), mpend[m]);
        end
        checks++;
        if (oc(m) !== 6'($countones(mpend[m]))) begin
          failures++; $display("[TB] FAIL rnd_count t=%0d m=%0d got=%0d exp=%0d", t, m, oc(m), $countones(mpend[m]));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifx.req = '0; irr.req = '0;
    ifx.clr = '0; irr.clr = '0;
    ifx.out_ready = 1'b0;
    irr.out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mpend[m] = '0; mptr[m] = 0; mval[m] = 1'b0; midx[m] = 0;
    end
    test_reset();
    test_single();
    test_fixed_order();
    test_rr_wrap();
    test_backpressure();
    test_repop_and_clr();
    test_reset_in_offer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
